// File: rtl/nla_pkg.sv
// Shared types, constants and helpers for the piecewise-polynomial sequencer.
package nla_pkg;

    localparam int NW      = 12;
    localparam int MUL_LAT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    // Default table [seg][k], sigmoid-like shape over four segments
    localparam logic [NW-1:0] COEF_DEF [4][4] = '{
        '{12'h800, 12'h3F0, 12'h010, 12'h000},
        '{12'h8F0, 12'h380, 12'h060, 12'h000},
        '{12'h9D0, 12'h2C0, 12'h0A0, 12'h000},
        '{12'hA80, 12'h1E0, 12'h0C0, 12'h000}
    };

    // Returns {overflow, clamped sum}
    function automatic logic [NW:0] sat_add(
        input logic [NW-1:0] a,
        input logic [NW-1:0] b
    );
        logic [NW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[NW] ? {1'b1, {NW{1'b1}}} : s;
    endfunction

endpackage

// File: rtl/nla_horner_seq_if.sv
// Argument, result and coefficient-write bundle of the Horner sequencer.
interface nla_horner_seq_if #(
    parameter int N        = 12,
    parameter int SEG_BITS = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_x;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_y;
    logic                out_sat;
    logic                cfg_we;
    logic [SEG_BITS+1:0] cfg_addr;
    logic [N-1:0]        cfg_data;

    modport master (
        output in_valid, in_x, out_ready,
        output cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_y, out_sat
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        input  cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/r4booth_even.sv
// Unsigned radix-4 Booth multiplier, four falling-edge stages from operands to product.
module r4booth_even #(
    parameter int N = 12
) (
    input  logic           clkn_i,
    input  logic           rstn_i,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_prod
);
    localparam int ND   = N / 2 + 1;
    localparam int HALF = ND / 2;
    localparam int W    = 2 * N;

    logic [N+2:0] w_bx;
    logic [W-1:0] w_pp [ND];
    logic [W-1:0] r_pp [ND];
    logic [W-1:0] w_lo, w_hi;
    logic [W-1:0] r_lo, r_hi, r_sum, r_prod;

    // Two zero bits on top keep the unsigned operand's last digit non-negative
    assign w_bx = {2'b00, i_b, 1'b0};

    function automatic logic [W-1:0] booth_pp(
        input logic [N-1:0] a,
        input logic [2:0]   t
    );
        logic [W-1:0] ax;
        ax = W'(a);
        unique case (t)
            3'b001, 3'b010: booth_pp = ax;
            3'b011:         booth_pp = ax << 1;
            3'b100:         booth_pp = -(ax << 1);
            3'b101, 3'b110: booth_pp = -ax;
            default:        booth_pp = '0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < ND; i++) begin
            w_pp[i] = booth_pp(i_a, w_bx[2*i +: 3]) << (2 * i);
        end
    end

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        for (int i = 0; i < HALF; i++) w_lo = w_lo + r_pp[i];
        for (int i = HALF; i < ND; i++) w_hi = w_hi + r_pp[i];
    end

    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ND; i++) r_pp[i] <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_sum  <= '0;
            r_prod <= '0;
        end else begin
            for (int i = 0; i < ND; i++) r_pp[i] <= w_pp[i];
            r_lo   <= w_lo;
            r_hi   <= w_hi;
            r_sum  <= r_lo + r_hi;
            r_prod <= r_sum;
        end
    end

    assign o_prod = r_prod;
endmodule

// File: rtl/nla_horner_seq.sv
// Horner-rule piecewise-polynomial sequencer time-sharing one Booth multiplier.
module nla_horner_seq
    import nla_pkg::*;
#(
    parameter int N        = NW,
    parameter int DEG      = 2,
    parameter int SEG_BITS = 2
) (
    input  logic             clkn_i,
    input  logic             rstn_i,
    nla_horner_seq_if.slave  bus
);
    localparam int NSEG = 1 << SEG_BITS;
    localparam int CW   = $clog2(MUL_LAT) + 1;

    state_t              r_state;
    logic [N-1:0]        r_coef [NSEG][DEG+1];
    logic [N-1:0]        r_x, r_y, r_op_a, r_op_b;
    logic [N-1:0]        r_out_y;
    logic [SEG_BITS-1:0] r_seg;
    logic [1:0]          r_k;
    logic [CW-1:0]       r_cnt;
    logic                r_sat, r_out_sat;
    logic                r_in_ready, r_out_valid;

    logic [N-1:0]        w_prod_hi;
    logic [N-1:0]        w_unused_prod_lo;
    logic [N:0]          w_sum;
    logic [SEG_BITS-1:0] w_in_seg, w_wseg;
    logic [1:0]          w_wk;
    logic                w_accept;

    r4booth_even #(.N(N)) u_mul (
        .clkn_i (clkn_i),
        .rstn_i (rstn_i),
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .o_prod ({w_prod_hi, w_unused_prod_lo})
    );

    assign w_in_seg = bus.in_x[N-1 -: SEG_BITS];
    assign {w_wseg, w_wk} = bus.cfg_addr;
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_sum = sat_add(w_prod_hi, r_coef[r_seg][r_k]);

    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < NSEG; s++)
                for (int k = 0; k <= DEG; k++)
                    r_coef[s][k] <= N'(COEF_DEF[s % 4][k]);
        end else if (bus.cfg_we && r_state == S_IDLE
                     && int'(w_wk) <= DEG) begin
            r_coef[w_wseg][w_wk] <= bus.cfg_data;
        end
    end

    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_seg       <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_y     <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_x        <= bus.in_x;
                        r_seg      <= w_in_seg;
                        r_y        <= r_coef[w_in_seg][DEG];
                        r_k        <= 2'(DEG - 1);
                        r_sat      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_op_a  <= r_y;
                    r_op_b  <= r_x;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CW'(MUL_LAT - 1)) r_state <= S_ACC;
                    else r_cnt <= r_cnt + 1'b1;
                end
                S_ACC: begin
                    r_y   <= w_sum[N-1:0];
                    r_sat <= r_sat | w_sum[N];
                    if (r_k == 2'd0) begin
                        r_out_y     <= w_sum[N-1:0];
                        r_out_sat   <= r_sat | w_sum[N];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k     <= r_k - 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_out_y;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_nla_horner_seq.sv
// Bench for nla_horner_seq: directed scenarios plus a randomized stream against a reference model.
module tb_nla_horner_seq;
    logic clkn_i = 1'b1;
    logic rstn_i = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   coef [4][3];

    nla_horner_seq_if #(.N(12), .SEG_BITS(2)) bus ();

    nla_horner_seq #(.N(12), .DEG(2), .SEG_BITS(2)) dut (
        .clkn_i (clkn_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    always #5 clkn_i = ~clkn_i;

    task automatic tick();
        @(negedge clkn_i);
        #1;
    endtask

    task automatic load_defaults();
        coef[0] = '{32'h800, 32'h3F0, 32'h010};
        coef[1] = '{32'h8F0, 32'h380, 32'h060};
        coef[2] = '{32'h9D0, 32'h2C0, 32'h0A0};
        coef[3] = '{32'hA80, 32'h1E0, 32'h0C0};
    endtask

    // Horner evaluation with truncating multiply and clamping add; returns {sat, y}
    function automatic logic [12:0] model(input logic [11:0] x);
        int seg = int'(x[11:10]);
        int xi  = int'(x);
        int y   = coef[seg][2];
        bit s   = 1'b0;
        for (int k = 1; k >= 0; k--) begin
            int t = ((y * xi) >> 12) + coef[seg][k];
            if (t > 4095) begin
                y = 4095;
                s = 1'b1;
            end else begin
                y = t;
            end
        end
        return {s, 12'(y)};
    endfunction

    task automatic cfg_write(input int seg, input int k,
                             input logic [11:0] d, input bit upd);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'({seg[1:0], k[1:0]});
        bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
        if (upd && k <= 2) coef[seg][k] = int'(d);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Counts edges from the accept edge to out_valid; -1 if it never came
    task automatic wait_valid(output int lat);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        lat = bus.out_valid ? n : -1;
    endtask

    task automatic do_eval(input logic [11:0] x, output logic [11:0] y,
                           output logic s, output int lat);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        y = bus.out_y;
        s = bus.out_sat;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rstn_i = 1'b0;
        tick();
        tick();
        checks += 4;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.out_y !== 12'h000) begin
            errors++;
            $display("FAIL reset_out_y got=%h exp=000", bus.out_y);
        end
        if (bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat);
        end
        rstn_i = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [11:0] y;
        logic s;
        int lat;
        cfg_write(2, 2, 12'h800, 1'b1);
        cfg_write(2, 1, 12'h400, 1'b1);
        cfg_write(2, 0, 12'h100, 1'b1);
        do_eval(12'h800, y, s, lat);
        checks += 3;
        if (y !== 12'h500) begin
            errors++;
            $display("FAIL basic_y got=%h exp=500", y);
        end
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL basic_sat got=%b exp=0", s);
        end
        if (lat != 12) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=12", lat);
        end
    endtask

    task automatic test_saturation();
        logic [11:0] y;
        logic s;
        int lat;
        cfg_write(3, 2, 12'hFFF, 1'b1);
        cfg_write(3, 1, 12'hFFF, 1'b1);
        cfg_write(3, 0, 12'h000, 1'b1);
        do_eval(12'hFFF, y, s, lat);
        checks += 2;
        if (y !== 12'hFFE) begin
            errors++;
            $display("FAIL sat_y got=%h exp=ffe", y);
        end
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag got=%b exp=1", s);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] x1 = 12'h5A3;
        logic [11:0] x2 = 12'hC41;
        logic [12:0] e1 = model(x1);
        logic [12:0] e2 = model(x2);
        int lat;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_x     = x1;
        tick();
        bus.in_x = x2;
        wait_valid(lat);
        checks++;
        if (lat != 12) begin
            errors++;
            $display("FAIL bp_latency got=%0d exp=12", lat);
        end
        for (int i = 0; i < 20; i++) begin
            checks += 3;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid);
            end
            if ({bus.out_sat, bus.out_y} !== e1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i,
                         {bus.out_sat, bus.out_y}, e1);
            end
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_bubble_ready got=%b exp=1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got=%b exp=0", bus.in_ready);
        end
        wait_valid(lat);
        checks += 2;
        if (lat != 12) begin
            errors++;
            $display("FAIL bp2_latency got=%0d exp=12", lat);
        end
        if ({bus.out_sat, bus.out_y} !== e2) begin
            errors++;
            $display("FAIL bp2_y got=%h exp=%h", {bus.out_sat, bus.out_y}, e2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_blocked_writes();
        logic [11:0] x = 12'h6B7;
        logic [12:0] e;
        logic [11:0] y;
        logic s;
        int lat;
        cfg_write(1, 3, 12'h777, 1'b1);
        e = model(x);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        tick();
        bus.in_valid = 1'b0;
        bus.in_x     = 12'h000;
        tick();
        tick();
        tick();
        cfg_write(1, 0, 12'h123, 1'b0);
        wait_valid(lat);
        checks += 2;
        if ({bus.out_sat, bus.out_y} !== e) begin
            errors++;
            $display("FAIL blocked_run got=%h exp=%h", {bus.out_sat, bus.out_y}, e);
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL blocked_timeout got=%0d exp=12", lat);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [11:0] xr = 12'(12'h400 + i * 12'h15B);
            e = model(xr);
            do_eval(xr, y, s, lat);
            checks++;
            if ({s, y} !== e) begin
                errors++;
                $display("FAIL blocked_readback x=%h got=%h exp=%h", xr, {s, y}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] y;
        logic s;
        int lat;
        cfg_write(0, 0, 12'h0AB, 1'b1);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_x     = 12'h3C5;
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        rstn_i = 1'b0;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_valid got=%b exp=0", bus.out_valid);
        end
        if (bus.out_y !== 12'h000) begin
            errors++;
            $display("FAIL rmid_y got=%h exp=000", bus.out_y);
        end
        if (bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL rmid_sat got=%b exp=0", bus.out_sat);
        end
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in_ready got=%b exp=0", bus.in_ready);
        end
        tick();
        tick();
        rstn_i = 1'b1;
        load_defaults();
        tick();
        do_eval(12'h000, y, s, lat);
        checks += 2;
        if (y !== 12'h800 || s !== 1'b0) begin
            errors++;
            $display("FAIL rmid_x0 got=%h/%b exp=800/0", y, s);
        end
        if (lat != 12) begin
            errors++;
            $display("FAIL rmid_latency got=%0d exp=12", lat);
        end
        for (int i = 1; i < 4; i++) begin
            logic [11:0] xr = 12'(i * 12'h400 + 12'h0F3);
            logic [12:0] e = model(xr);
            do_eval(xr, y, s, lat);
            checks++;
            if ({s, y} !== e) begin
                errors++;
                $display("FAIL rmid_default x=%h got=%h exp=%h", xr, {s, y}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] q[$];
        logic [12:0] e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit acc_in, acc_out;
        for (int sg = 0; sg < 4; sg++)
            for (int k = 0; k < 3; k++)
                cfg_write(sg, k, 12'($urandom), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_x     = 12'($urandom);
        while (got < 100 && cyc < 6000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            acc_in  = bus.in_valid && bus.in_ready;
            acc_out = bus.out_valid && bus.out_ready;
            if (acc_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got=%h exp=none", {bus.out_sat, bus.out_y});
                end else begin
                    e = q.pop_front();
                    if ({bus.out_sat, bus.out_y} !== e) begin
                        errors++;
                        $display("FAIL b2b_y n=%0d got=%h exp=%h", got,
                                 {bus.out_sat, bus.out_y}, e);
                    end
                end
                got++;
            end
            if (acc_in) q.push_back(model(bus.in_x));
            tick();
            cyc++;
            if (acc_in) begin
                sent++;
                if (sent < 100) bus.in_x = 12'($urandom);
                else bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (got != 100) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=100", got);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        load_defaults();
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_blocked_writes();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nla_horner_seq.md
# nla_horner_seq

Piecewise-polynomial evaluation sequencer for the nonlinear approximation engine. It accepts an unsigned fixed-point argument x and selects a coefficient set by segment. It evaluates y = (((c_DEG·x + c_DEG-1)·x + …) + c0) with Horner's rule. Each multiply is time-shared through one r4booth_even radix-4 Booth multiplier, which sits directly downstream of this controller's operand registers. It is the front end that turns the multiplier into a sigmoid/tanh/exp-style approximator.

## Interface
- N, 12: data width. Q0.N unsigned fraction for x, coefficients and y; must be even and match the multiplier.
- DEG, 2: polynomial degree, 1..3.
- SEG_BITS, 2: segment index width; the segment is x[N-1:N-SEG_BITS].
- MUL_LAT, 4: falling edges from the multiplier sampling its operands to its product register updating. Fixed by r4booth_even.
- Clock and reset: one clock, `clkn_i`; all state updates on its falling edge. Reset `rstn_i` is asynchronous and active-low.
- clkn_i  in  1  clock; all flops falling-edge triggered
- rstn_i  in  1  asynchronous active-low reset; also drives the multiplier instance
- in_valid  in  1  argument valid
- in_ready  out  1  high only in IDLE; reset 0 while in reset, 1 after
- in_x  in  N  argument, Q0.N
- out_valid  out  1  result valid; reset 0
- out_ready  in  1  consumer accepts result
- out_y  out  N  result, Q0.N; reset 0
- out_sat  out  1  sticky saturation flag for this result; reset 0
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  SEG_BITS+2  {segment, k}; k = coefficient index 0..DEG
- cfg_data  in  N  coefficient value, Q0.N

## Operation
- Coefficient file: 2^SEG_BITS × (DEG+1) registers of N bits.
  - Reset loads the package default table.
  - A write commits on the falling edge when cfg_we=1, state=IDLE and k≤DEG.
  - All other writes are dropped: while busy, or with k>DEG.
- FSM states: IDLE, ISSUE, WAIT, ACC, DONE.
- IDLE: in_ready=1. On in_valid: latch x, seg, y←C[seg][DEG], k←DEG-1, sat←0, go ISSUE.
- ISSUE: load multiplier operand registers, multiplicand=y and multiplier=x. Clear wait counter. Go WAIT.
- WAIT: count MUL_LAT cycles, then go ACC.
- ACC: sum = product[2N-1:N] + C[seg][k], N+1 bits; the product is truncated, not rounded.
  - If sum[N]=1: y←all-ones and sat←1. Otherwise y←sum[N-1:0].
  - If k=0, go DONE. Otherwise k←k-1 and go ISSUE.
- DONE: out_valid=1, out_y=y, out_sat=sat, all held stable.
  - On out_ready, go IDLE.
  - A new argument cannot be accepted in the same cycle: one bubble.
- Operand registers hold their values outside ISSUE. The multiplier pipeline keeps running; its product is consumed only in ACC.
- in_x and coefficient changes during evaluation do not affect the running result, because x is latched and coefficient writes are blocked.
- Reset mid-evaluation aborts the evaluation. All state, the coefficient file and the multiplier pipeline return to reset values. No result is produced.

## Timing
- The accept edge is a.
- Each Horner step takes MUL_LAT+2 cycles: ISSUE 1, WAIT MUL_LAT, ACC 1.
- out_valid first high after edge a + DEG·(MUL_LAT+2). With the defaults that is a+12.
- Throughput with out_ready tied high: one result per DEG·(MUL_LAT+2)+2 cycles.
- out_valid stays high until accepted, with no limit. in_ready stays 0 from the accept edge until the DONE→IDLE edge.

## Structure
- Shared package nla_pkg holds:
  - the state enum;
  - the MUL_LAT constant;
  - the default coefficient table as a localparam array indexed [seg][k];
  - a saturating-add function.
- One sub-module: r4booth_even #(.N(N)), with clkn_i and rstn_i connected directly. The coefficient file and FSM stay in this module.

## Test plan
- Basic evaluation:
  - Stimulus: write seg2 c2=0x800, c1=0x400, c0=0x100. Send x=0x800.
  - Required: out_y=0x500, out_sat=0, out_valid exactly 12 cycles after the accept edge.
- Saturation:
  - Stimulus: write seg3 c2=0xFFF, c1=0xFFF, c0=0x000. Send x=0xFFF.
  - Required: step1 saturates to 0xFFF; final out_y=0xFFE with out_sat=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles, with in_valid held high carrying a second x.
  - Required: out_y stable, in_ready=0 throughout. The second x is accepted only on the cycle after the out handshake.
- Blocked writes:
  - Stimulus: cfg_we=1 to the active segment's c0 mid-evaluation, and a write with k=3 while DEG=2.
  - Required: result uses the old c0; both writes are absent when read back through a later evaluation.
- Reset mid-operation:
  - Stimulus: assert rstn_i=0 during WAIT of step 2.
  - Required: immediately out_valid=0, out_y=0, out_sat=0, and in_ready low during reset.
  - Required: after release, coefficients are the package defaults, and x=0 returns default C[0][0].
- Back-to-back:
  - Stimulus: 100 random x values with random out_ready.
  - Required: every out_y matches a bit-exact truncate/saturate reference model, in order.
